// File: rtl/maxpool_seq.sv
// Window sequencer that sits upstream of maxpool. It accepts a valid/ready stream of
// signed values and drives maxpool's controls so that each window reduces to its maximum.
// It then captures maxpool's result into a one-entry output register. That register is
// presented downstream on a valid/ready handshake.
module maxpool_seq #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cfg_win,
  input  logic          cfg_load,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          max_en,
  output logic          max_clr,
  output logic          max_pool,
  output logic [N-1:0]  max_I,
  input  logic [N-1:0]  max_O,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [CW-1:0] win_cnt
);

  // FILL accepts window values. CAP is the single cycle (or more, when stalled) in which
  // maxpool's O already holds the finished window maximum.
  typedef enum logic [0:0] {StFill, StCap} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] win_q, win_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;

  logic          acc;
  logic          load_take;
  logic [CW-1:0] cfg_win_eff;
  logic [CW-1:0] win_cur;
  logic          last_val;
  logic          capture;

  // Handshake and maxpool control outputs.
  always_comb begin
    in_ready  = (state_q == StFill);
    acc       = in_valid & in_ready;
    max_en    = acc;
    max_clr   = rst;
    max_pool  = (cnt_q != '0);
    max_I     = in_data;
    out_valid = out_valid_q;
    out_data  = out_data_q;
    win_cnt   = cnt_q;
  end

  // Window-length bookkeeping. A load taken alongside an accept governs the window that
  // this accept starts, so the end-of-window test uses the incoming length.
  always_comb begin
    cfg_win_eff = (cfg_win == '0) ? CW'(1) : cfg_win;
    load_take   = cfg_load && (state_q == StFill) && (cnt_q == '0);
    win_cur     = load_take ? cfg_win_eff : win_q;
    last_val    = (cnt_q == win_cur - CW'(1));
    capture     = (state_q == StCap) && (!out_valid_q || out_ready);
  end

  // Next-state logic for the window FSM, the counter and the output register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_cur;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    // Downstream drains the register; a same-cycle capture below overrides this.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StFill: begin
        if (acc) begin
          if (last_val || flush) begin
            cnt_d   = '0;
            state_d = StCap;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (flush && (cnt_q != '0)) begin
          // An empty window is never emitted, so a flush at cnt==0 does nothing.
          cnt_d   = '0;
          state_d = StCap;
        end
      end
      StCap: begin
        if (capture) begin
          out_data_d  = max_O;
          out_valid_d = 1'b1;
          state_d     = StFill;
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  // State registers; reset abandons any partial window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      cnt_q       <= '0;
      win_q       <= CW'(1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // The counter never runs past the end of the configured window.
  cnt_in_window: assert property (@(posedge clk) disable iff (rst) cnt_q <= win_q - CW'(1));

endmodule

// File: tb/tb_maxpool_seq.sv
// Directed bench for maxpool_seq with a behavioural maxpool attached to its controls.
module tb_maxpool_seq;
  localparam int unsigned N  = 32;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cfg_win;
  logic          cfg_load;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          max_en;
  logic          max_clr;
  logic          max_pool;
  logic [N-1:0]  max_I;
  logic [N-1:0]  max_O;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [CW-1:0] win_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [N-1:0] got_q[$];
  logic [N-1:0] exp_q[$];

  maxpool_seq #(.N(N), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_win  (cfg_win),
    .cfg_load (cfg_load),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .max_en   (max_en),
    .max_clr  (max_clr),
    .max_pool (max_pool),
    .max_I    (max_I),
    .max_O    (max_O),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .win_cnt  (win_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural maxpool: clear to 0, plain set when pool is low, signed max otherwise.
  always @(posedge clk) begin
    if (max_clr) max_O <= '0;
    else if (max_en) begin
      if (!max_pool) max_O <= max_I;
      else if ($signed(max_I) > $signed(max_O)) max_O <= max_I;
    end
  end

  // Record every completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back(out_data);
  end

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got,
               $signed(exp), exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one value and hold it until accepted; returns the controls seen at accept.
  task automatic send(input int v, output logic pool, output logic [CW-1:0] cnt);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v;
    #1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("send_timeout", 32'd1, 32'd0);
    pool = max_pool;
    cnt  = win_cnt;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic load(input int w);
    cfg_win  = w[CW-1:0];
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  logic          p;
  logic [CW-1:0] c;
  int            n_before;
  int            v4[4];
  logic          p4[4];
  logic [CW-1:0] c4[4];

  initial begin
    rst = 1'b1; cfg_win = '0; cfg_load = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    check("clr_in_reset", {31'd0, max_clr}, 32'd1);
    step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_win_cnt", {24'd0, win_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_max_clr", {31'd0, max_clr}, 32'd0);

    // 1: default window of one value, each out two edges after its accept.
    send(3, p, c);
    check("t1_pool", {31'd0, p}, 32'd0);
    check("t1_cap_valid", {31'd0, out_valid}, 32'd0);
    check("t1_cap_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_data", out_data, 32'd3);
    send(-7, p, c);
    send(5, p, c);
    exp_q.push_back(32'd3); exp_q.push_back(-32'sd7); exp_q.push_back(32'd5);
    drain();

    // 2: window of four; pool and count progress across the window.
    load(4);
    v4 = '{-4, 9, 1, -1};
    for (int i = 0; i < 4; i++) send(v4[i], p4[i], c4[i]);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_pool%0d", i), {31'd0, p4[i]}, (i == 0) ? 32'd0 : 32'd1);
      check($sformatf("t2_cnt%0d", i), {24'd0, c4[i]}, i);
    end
    step();
    check("t2_data", out_data, 32'd9);
    exp_q.push_back(32'd9);
    drain();

    // 3: all-negative window.
    load(3);
    send(-8, p, c); send(-2, p, c); send(-5, p, c);
    step();
    check("t3_data", out_data, -32'sd2);
    exp_q.push_back(-32'sd2);
    drain();

    // 4: back-pressure across two windows.
    load(4);
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(i, p, c);
    repeat (3) step();
    check("t4_stall_ready", {31'd0, in_ready}, 32'd0);
    check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
    check("t4_hold_data", out_data, 32'd4);
    out_ready = 1'b1;
    step();
    check("t4_second", out_data, 32'd8);
    exp_q.push_back(32'd4); exp_q.push_back(32'd8);
    drain();

    // 5: flush without accept ends a partial window; flush at cnt==0 emits nothing.
    send(6, p, c); send(2, p, c);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("t5_data", out_data, 32'd6);
    exp_q.push_back(32'd6);
    drain();
    n_before = got_q.size();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();
    check("t5_empty_flush", got_q.size(), n_before);
    check("t5_empty_ready", {31'd0, in_ready}, 32'd1);

    // 6: reset mid-window.
    send(10, p, c); send(20, p, c);
    check("t6_cnt_before", {24'd0, win_cnt}, 32'd2);
    rst = 1'b1;
    #1;
    check("t6_clr", {31'd0, max_clr}, 32'd1);
    step();
    rst = 1'b0;
    #1;
    check("t6_cnt", {24'd0, win_cnt}, 32'd0);
    check("t6_valid", {31'd0, out_valid}, 32'd0);
    send(7, p, c);
    step();
    check("t6_data", out_data, 32'd7);
    exp_q.push_back(32'd7);
    drain();

    // 7: load taken with the first value governs that window.
    cfg_win = 8'd2; cfg_load = 1'b1;
    send(4, p, c);
    cfg_load = 1'b0;
    check("t7_cnt", {24'd0, win_cnt}, 32'd1);
    send(1, p, c);
    exp_q.push_back(32'd4);
    drain();

    // 8: mid-window load is ignored; flush with accept ends the window.
    send(5, p, c);
    cfg_win = 8'd1; cfg_load = 1'b1;
    send(9, p, c);
    cfg_load = 1'b0;
    exp_q.push_back(32'd9);
    drain();
    send(3, p, c);
    check("t8_win_kept", {24'd0, win_cnt}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.push_back(32'd3);
    drain();
    flush = 1'b1;
    send(8, p, c);
    flush = 1'b0;
    exp_q.push_back(32'd8);
    drain();

    // 9: a window length of 0 behaves as 1.
    load(0);
    send(11, p, c); send(-3, p, c);
    exp_q.push_back(32'd11); exp_q.push_back(-32'sd3);
    drain();

    check("n_outputs", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("out%0d", i), got_q[i], exp_q[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
